// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the calculator display path.
// Optional leading-zero blanking is enabled by defining RESULT_BCD_BLANK_EN.
module result_bcd_converter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   shreg;
    logic [SCR_W-1:0]   scr;
    logic [CNT_W-1:0]   cnt;
    logic               load, shift, fin;
    logic               busy_nx, done_nx;

    function automatic logic [SCR_W-1:0] dabble(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load    = (state == IDLE) && start;
        shift   = (state == SHIFT);
        fin     = (state == DONE);
        busy_nx = (state_nx != IDLE);
        done_nx = fin;
    end

    // Conversion datapath: operand, scratch digits and bit counter, no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= bin;
            scr   <= '0;
            cnt   <= CNT_LOAD;
        end else if (shift) begin
            {scr, shreg} <= {dabble(scr), shreg} << 1;
            cnt          <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
            ovf  <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            if (fin) begin
                if (scr[SCR_W-1 -: 4] != 4'd0) begin
                    ovf <= 1'b1;
                    bcd <= {DIGITS{4'h9}};
                end else begin
                    ovf <= 1'b0;
                    bcd <= scr[4*DIGITS-1:0];
                end
            end
        end
    end

`ifdef RESULT_BCD_BLANK_EN
    // A digit blanks only when it and every more significant digit are zero.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero;
        m    = '0;
        zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero = zero && (v[4*i +: 4] == 4'd0);
            m[i] = zero;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        else if (fin) begin
            if (scr[SCR_W-1 -: 4] != 4'd0)
                blank <= '0;
            else
                blank <= blank_mask(scr[4*DIGITS-1:0]);
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: directed table, corner sequences,
// a partial sweep and random operands against an arithmetic digit-split model.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [13:0] bin;
    logic        busy, done, ovf;
    logic [15:0] bcd;
    logic [3:0]  blank;

    int checks = 0;
    int errors = 0;

`ifdef RESULT_BCD_BLANK_EN
    localparam bit         BLANK_ON  = 1'b1;
    localparam logic [3:0] BLANK_RST = 4'b1110;
`else
    localparam bit         BLANK_ON  = 1'b0;
    localparam logic [3:0] BLANK_RST = 4'b0000;
`endif

    always #5 clk = ~clk;

    result_bcd_converter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf),
        .blank (blank)
    );

    typedef struct {
        logic [13:0] b;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank_m;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input int b, output logic [15:0] e_bcd,
                                  output logic e_ovf, output logic [3:0] e_blank);
        if (b > 9999) begin
            e_bcd   = 16'h9999;
            e_ovf   = 1'b1;
            e_blank = 4'b0000;
        end else begin
            e_bcd   = {4'(b / 1000), 4'((b / 100) % 10), 4'((b / 10) % 10), 4'(b % 10)};
            e_ovf   = 1'b0;
            e_blank = BLANK_ON ? {b < 1000, b < 100, b < 10, 1'b0} : 4'b0000;
        end
    endfunction

    // Start a conversion, scramble bin after the start edge, check timing and results.
    task automatic conv(input string tag, input logic [13:0] b, input logic [15:0] e_bcd,
                        input logic e_ovf, input logic [3:0] e_blank);
        int n, busy_cnt;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bin      = 14'($urandom);
        chk({tag, "_done_low_after_start"}, done, 0);
        busy_cnt = busy ? 1 : 0;
        n        = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_latency"}, n, 15);
        chk({tag, "_busy_cycles"}, busy_cnt, 15);
        chk({tag, "_bcd"}, bcd, e_bcd);
        chk({tag, "_ovf"}, ovf, e_ovf);
        chk({tag, "_blank"}, blank, e_blank);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk({tag, "_no_done"}, seen, 0);
    endtask

    initial begin
        logic [15:0] e_bcd;
        logic        e_ovf;
        logic [3:0]  e_blank;
        int          n;

        vecs[0] = '{14'd0,     16'h0000, 1'b0, 4'b1110};
        vecs[1] = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
        vecs[3] = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
        vecs[4] = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
        vecs[5] = '{14'd300,   16'h0300, 1'b0, 4'b1000};
        vecs[6] = '{14'd90,    16'h0090, 1'b0, 4'b1100};
        vecs[7] = '{14'd1005,  16'h1005, 1'b0, 4'b0000};

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_blank", blank, BLANK_RST);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            conv($sformatf("vec%0d", i), vecs[i].b, vecs[i].bcd, vecs[i].ovf,
                 BLANK_ON ? vecs[i].blank_m : 4'b0000);

        // Second start at E5 must be ignored.
        @(negedge clk);
        bin   = 14'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 14'd99;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd55;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 5;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ignored_start_latency", n, 15);
        chk("ignored_start_bcd", bcd, 16'h0007);
        chk("ignored_start_blank", blank, BLANK_ON ? 4'b1110 : 4'b0000);
        conv("b2b_55", 14'd55, 16'h0055, 1'b0, BLANK_ON ? 4'b1100 : 4'b0000);

        // Reset at E7 aborts a conversion of 300.
        conv("pre_abort_42", 14'd42, 16'h0042, 1'b0, BLANK_ON ? 4'b1100 : 4'b0000);
        @(negedge clk);
        bin   = 14'd300;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bcd", bcd, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_blank", blank, BLANK_RST);
        @(negedge clk);
        rst = 1'b0;
        watch_no_done("abort", 24);
        conv("post_abort_300", 14'd300, 16'h0300, 1'b0, BLANK_ON ? 4'b1000 : 4'b0000);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd5;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_bcd", bcd, 0);
        watch_no_done("rst_start", 20);

        // Partial back-to-back sweep, ranges at both ends of the valid span.
        for (int v = 0; v < 400; v++) begin
            model(v, e_bcd, e_ovf, e_blank);
            conv("sweep_lo", 14'(v), e_bcd, e_ovf, e_blank);
        end
        for (int v = 9900; v < 10010; v++) begin
            model(v, e_bcd, e_ovf, e_blank);
            conv("sweep_hi", 14'(v), e_bcd, e_ovf, e_blank);
        end

        // Random operands over the full 14-bit range.
        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(16383, 0));
            model(r, e_bcd, e_ovf, e_blank);
            conv("rand", 14'(r), e_bcd, e_ovf, e_blank);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
